// File: rtl/rtc_bus_scheduler_if.sv
// rtc_bus_scheduler_if: request, scan-result and RTC pin bundle.
// master = scheduler side, slave = processor/RTC side.
interface rtc_bus_scheduler_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       scan_en;
  logic [7:0] rd_data;
  logic [3:0] rd_index;
  logic       rd_valid;
  logic       scan_done;
  logic       busy;
  logic       rtc_cs_n;
  logic       rtc_rd_n;
  logic       rtc_wr_n;
  logic       rtc_a_d;
  logic [7:0] rtc_ad_out;
  logic       rtc_ad_oe;
  logic [7:0] rtc_ad_in;

  modport master (
    input  wr_req, wr_addr, wr_data,
    input  scan_en, rtc_ad_in,
    output wr_ack, rd_data, rd_index,
    output rd_valid, scan_done, busy,
    output rtc_cs_n, rtc_rd_n, rtc_wr_n,
    output rtc_a_d, rtc_ad_out, rtc_ad_oe
  );

  modport slave (
    output wr_req, wr_addr, wr_data,
    output scan_en, rtc_ad_in,
    input  wr_ack, rd_data, rd_index,
    input  rd_valid, scan_done, busy,
    input  rtc_cs_n, rtc_rd_n, rtc_wr_n,
    input  rtc_a_d, rtc_ad_out, rtc_ad_oe
  );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler: arbitrates processor writes and a periodic
// 9-slot read scan onto the multiplexed RTC address/data bus.
// Ports: clk_i, reset_i (sync, active-high), bus (master modport:
// write request/ack, scan results, RTC strobes and bus pins).
module rtc_bus_scheduler #(
  parameter int T_PHASE     = 10,
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk_i,
  input  logic reset_i,
  rtc_bus_scheduler_if.master bus
);

  localparam int CW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] PH_LAST  = CW'(T_PHASE - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [3:0]    SLOT_LAST = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AHOLD, S_DATA, S_RECOV
  } state_e;

  function automatic logic [7:0] scan_addr(input logic [3:0] s);
    case (s)
      4'd0:    scan_addr = 8'h21;
      4'd1:    scan_addr = 8'h22;
      4'd2:    scan_addr = 8'h23;
      4'd3:    scan_addr = 8'h24;
      4'd4:    scan_addr = 8'h25;
      4'd5:    scan_addr = 8'h26;
      4'd6:    scan_addr = 8'h41;
      4'd7:    scan_addr = 8'h42;
      default: scan_addr = 8'h43;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] ref_q;
  logic          pend_q, active_q, is_wr_q;
  logic [3:0]    slot_q;
  logic [7:0]    ad_out_q, data_q, rdbuf_q;
  logic [7:0]    rd_data_q;
  logic [3:0]    rd_index_q;
  logic          wr_ack_q, rd_valid_q, scan_done_q;

  logic ph_last, grant_wr, grant_rd;
  logic tick, done, rd_busy;
  logic cs_n, rd_n, wr_n, a_d, oe;

  assign ph_last  = (cnt_q == PH_LAST);
  assign grant_wr = (state_q == S_IDLE) && bus.wr_req;
  assign grant_rd = (state_q == S_IDLE) && !bus.wr_req &&
                    bus.scan_en && (active_q || pend_q);
  assign tick     = bus.scan_en && (ref_q == REF_LAST);
  assign done     = (state_q == S_RECOV) && ph_last;
  // A scan read still on the bus must finish and report
  assign rd_busy  = (state_q != S_IDLE) && !is_wr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_wr || grant_rd) state_d = S_ADDR;
      S_ADDR:  if (ph_last) state_d = S_AHOLD;
      S_AHOLD: if (ph_last) state_d = S_DATA;
      S_DATA:  if (ph_last) state_d = S_RECOV;
      S_RECOV: if (ph_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cs_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    a_d  = 1'b1;
    oe   = 1'b0;
    unique case (state_q)
      S_ADDR: begin
        cs_n = 1'b0;
        wr_n = 1'b0;
        a_d  = 1'b0;
        oe   = 1'b1;
      end
      S_AHOLD: oe = 1'b1;
      S_DATA: begin
        cs_n = 1'b0;
        if (is_wr_q) begin
          wr_n = 1'b0;
          oe   = 1'b1;
        end else begin
          rd_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      ref_q       <= '0;
      pend_q      <= 1'b0;
      active_q    <= 1'b0;
      is_wr_q     <= 1'b0;
      slot_q      <= '0;
      ad_out_q    <= '0;
      data_q      <= '0;
      rdbuf_q     <= '0;
      rd_data_q   <= '0;
      rd_index_q  <= '0;
      wr_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      wr_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      scan_done_q <= 1'b0;
      if (state_q == S_IDLE || ph_last) cnt_q <= '0;
      else                              cnt_q <= cnt_q + CW'(1);
      if (!bus.scan_en || tick) ref_q <= '0;
      else                      ref_q <= ref_q + RW'(1);
      if (grant_wr) begin
        is_wr_q  <= 1'b1;
        ad_out_q <= bus.wr_addr;
        data_q   <= bus.wr_data;
      end
      if (grant_rd) begin
        is_wr_q  <= 1'b0;
        ad_out_q <= scan_addr(slot_q);
        active_q <= 1'b1;
        if (slot_q == '0) pend_q <= 1'b0;
      end
      if (state_q == S_AHOLD && ph_last && is_wr_q)
        ad_out_q <= data_q;
      if (state_q == S_DATA && ph_last)
        rdbuf_q <= bus.rtc_ad_in;
      if (done && is_wr_q) wr_ack_q <= 1'b1;
      if (done && !is_wr_q) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= rdbuf_q;
        rd_index_q <= slot_q;
        if (slot_q == SLOT_LAST || !bus.scan_en) begin
          slot_q      <= '0;
          active_q    <= 1'b0;
          scan_done_q <= (slot_q == SLOT_LAST) && bus.scan_en;
        end else begin
          slot_q <= slot_q + 4'd1;
        end
      end
      if (!bus.scan_en) begin
        pend_q <= 1'b0;
        if (!rd_busy) begin
          active_q <= 1'b0;
          slot_q   <= '0;
        end
      end
      // A tick during a scan queues exactly one follow-up scan
      if (tick) pend_q <= 1'b1;
    end
  end

  assign bus.rtc_cs_n   = cs_n;
  assign bus.rtc_rd_n   = rd_n;
  assign bus.rtc_wr_n   = wr_n;
  assign bus.rtc_a_d    = a_d;
  assign bus.rtc_ad_oe  = oe;
  assign bus.rtc_ad_out = ad_out_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.wr_ack     = wr_ack_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.scan_done  = scan_done_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_index   = rd_index_q;

endmodule

// File: doc/rtc_bus_scheduler.md
# rtc_bus_scheduler

Sequences every access to the external RTC chip over its multiplexed address/data bus. It arbitrates between processor write requests (time/date/timer setting) and a periodic read scan that refreshes the nine time-keeping registers (seconds through year, plus the timer's h/m/s). It sits between the processor-side register file and the RTC pins, and owns all bus timing.

## Interface
- T_PHASE, 10: clock cycles per bus phase, ≥1.
- REFRESH_DIV, 100000: clock cycles between scan starts while scan_en=1, ≥2.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; polarity/synchronicity fixed
- wr_req  in  1  write request, level; held until wr_ack
- wr_addr  in  8  RTC register address for write
- wr_data  in  8  write data
- wr_ack  out  1  one-cycle pulse: write finished
- scan_en  in  1  enables periodic read scan
- rd_data  out  8  data of last completed scan read
- rd_index  out  4  scan slot 0..8 of rd_data
- rd_valid  out  1  one-cycle pulse: rd_data/rd_index updated
- scan_done  out  1  one-cycle pulse with rd_valid of slot 8
- busy  out  1  bus transaction in progress
- rtc_cs_n, rtc_rd_n, rtc_wr_n  out  1 each  RTC strobes, active-low
- rtc_a_d  out  1  0 = address phase, 1 = data
- rtc_ad_out  out  8  bus drive value
- rtc_ad_oe  out  1  1 = FPGA drives the bus
- rtc_ad_in  in  8  bus sample value

## Operation
- Scan table, slots 0..8: 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year, 0x41 timer-sec, 0x42 timer-min, 0x43 timer-hour.
- Transaction states: IDLE → ADDR → AHOLD → DATA → RECOV → IDLE. Each non-IDLE state lasts exactly T_PHASE cycles.
  - ADDR: cs_n=0, wr_n=0, a_d=0, oe=1, ad_out=address.
  - AHOLD: cs_n=1, wr_n=1, a_d=1, oe=1, ad_out held.
  - DATA, write: cs_n=0, wr_n=0, oe=1, ad_out=data.
  - DATA, read: cs_n=0, rd_n=0, oe=0.
  - RECOV: all strobes high, oe=0.
- Arbitration is decided only in IDLE. Priority: wr_req first, then the active or pending scan. Writes may interleave between scan slots; a started transaction is never interrupted.
- Address and data are latched at grant. Dropping wr_req after grant does not cancel the write.
- Refresh counter:
  - Counts while scan_en=1 and is cleared while scan_en=0.
  - At REFRESH_DIV-1 it wraps and sets scan_pending.
  - Only one pending scan is kept; a tick during an active scan sets pending, and the next scan starts after scan_done.
  - A scan starts at slot 0 and advances one slot per read; pending is cleared when slot 0 is granted.
- scan_en low: clears pending. An active scan stops after the current transaction with no scan_done, and the next scan restarts at slot 0.
- Reset values: strobes=1, a_d=1, ad_out=0, oe=0, rd_data=0, rd_index=0, wr_ack=rd_valid=scan_done=busy=0. State=IDLE, counter=0, pending=0, slot=0.
- Reset mid-transaction forces all outputs to these values at the next edge. The interrupted write is not acknowledged.

## Timing
- Grant edge at cycle 0: ADDR occupies cycles 0..T-1, AHOLD T..2T-1, DATA 2T..3T-1, RECOV 3T..4T-1. T = T_PHASE.
- Read data is sampled from rtc_ad_in on the edge ending cycle 3T-1.
- wr_ack, or rd_valid (plus scan_done for slot 8), is high during cycle 4T, the first IDLE cycle.
- IDLE lasts at least one cycle; back-to-back grants are 4T+1 cycles apart.
- wr_req sampled high in IDLE at cycle k produces wr_ack at cycle k+1+4T.
- busy is high in cycles 0..4T-1.
- Full scan with no writes: 9·(4T+1) cycles.

## Test plan
- Reset, then idle with T_PHASE=2 and scan_en=0: all outputs at reset values; no bus activity for 200 cycles.
- Write 0x21←0x59: check the strobe/a_d/oe/ad_out sequence per phase and that wr_ack occurs exactly 9 cycles after the request is seen.
- scan_en=1, REFRESH_DIV=64, RTC model returns address XOR 0xFF:
  - nine rd_valid pulses, slots 0..8, with rd_data 0xDE…0xBC;
  - scan_done with slot 8;
  - the next scan starts at the next tick.
- wr_req asserted during slot 3 of a scan: the write is granted right after slot 3 completes, and the scan resumes at slot 4.
- scan_en dropped during slot 5: slot 5 completes with rd_valid, then no further reads and no scan_done. Re-enabling restarts at slot 0.
- reset pulsed during DATA of a write: outputs idle next cycle, no wr_ack, and the next scan starts at slot 0.
